// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-select width and the hazard sequencer state encoding.
package cpu_types_pkg;

  localparam int REGBITS = 5;

  typedef logic [REGBITS-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clear has priority over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: latch enables/flushes and PC enable for the 5-stage datapath,
// with data-wait / halt tracking and saturating stall and flush counters.
module hazard_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_jump_taken,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzstate_t   state, state_next;
  logic       dstall, ldhaz;
  logic [7:0] ctrl;
  logic       dstall_inc, istall_inc, flush_inc;
  logic       halted_q;
  logic [CNT_W-1:0] dstall_q, istall_q, flush_q;

  assign dstall = (mem_dREN | mem_dWEN) & ~dhit;
  assign ldhaz  = ex_dREN & (ex_wsel != '0) &
                  ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  // ctrl = {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}.
  // RUN and DWAIT share one priority chain: a DWAIT cycle that sees dhit falls through to it.
  always_comb begin
    ctrl       = 8'b0000_0000;
    state_next = state;
    dstall_inc = 1'b0;
    istall_inc = 1'b0;
    flush_inc  = 1'b0;
    if (state != HALTED) begin
      if (dstall) begin
        state_next = DWAIT;
        dstall_inc = 1'b1;
      end else if (mem_halt) begin
        ctrl       = 8'b0001_1001;
        state_next = HALTED;
      end else if (ex_jump_taken) begin
        ctrl       = 8'b1111_1110;
        state_next = RUN;
        flush_inc  = 1'b1;
      end else if (ldhaz) begin
        ctrl       = 8'b0011_1010;
        state_next = RUN;
      end else if (!ihit) begin
        ctrl       = 8'b0111_1100;
        state_next = RUN;
        istall_inc = 1'b1;
      end else begin
        ctrl       = 8'b1111_1000;
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      halted_q <= 1'b0;
    end else begin
      state    <= state_next;
      halted_q <= (state_next == HALTED);
    end
  end

  sat_counter #(.W(CNT_W)) u_dstall_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (dstall_inc),
    .count (dstall_q)
  );

  sat_counter #(.W(CNT_W)) u_istall_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (istall_inc),
    .count (istall_q)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (flush_inc),
    .count (flush_q)
  );

  // Reset forces every output low, including registers that have not yet seen the edge.
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, exmem_flush} = RST ? 8'b0000_0000 : ctrl;
  assign halted     = halted_q & ~RST;
  assign dstall_cnt = RST ? '0 : dstall_q;
  assign istall_cnt = RST ? '0 : istall_q;
  assign flush_cnt  = RST ? '0 : flush_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_sequencer;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int W     = 9 + 3 * CNT_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             rst;
    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             mem_halt;
    logic             ex_dren;
    logic [REG_W-1:0] ex_wsel;
    logic             ex_jump;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
  } stim_t;

  logic             clk = 1'b0;
  logic             rst, ihit, dhit, mem_dren, mem_dwen, mem_halt, ex_dren, ex_jump, id_uses_rt;
  logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNT_W-1:0] dstall_cnt, istall_cnt, flush_cnt;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  // Behavioural model state
  bit           mdl_halted = 0;
  int unsigned  mdl_dstall = 0, mdl_istall = 0, mdl_flush = 0;

  hazard_sequencer #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK           (clk),
    .RST           (rst),
    .ihit          (ihit),
    .dhit          (dhit),
    .mem_dREN      (mem_dren),
    .mem_dWEN      (mem_dwen),
    .mem_halt      (mem_halt),
    .ex_dREN       (ex_dren),
    .ex_wsel       (ex_wsel),
    .ex_jump_taken (ex_jump),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .halted        (halted),
    .dstall_cnt    (dstall_cnt),
    .istall_cnt    (istall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s      = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic int unsigned sat_inc(int unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Driver: apply one cycle of stimulus, push the expected response, advance the model.
  task automatic step(input stim_t s);
    logic [7:0] ctrl;
    bit         mem_busy, hazard;
    @(posedge clk);
    #1;
    rst = s.rst; ihit = s.ihit; dhit = s.dhit; mem_dren = s.mem_dren; mem_dwen = s.mem_dwen;
    mem_halt = s.mem_halt; ex_dren = s.ex_dren; ex_wsel = s.ex_wsel; ex_jump = s.ex_jump;
    id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
    ctrl = 8'h00;
    if (s.rst) begin
      exp_q.push_back('0);
      mdl_halted = 0; mdl_dstall = 0; mdl_istall = 0; mdl_flush = 0;
    end else if (mdl_halted) begin
      exp_q.push_back({8'h00, 1'b1, mdl_dstall[CNT_W-1:0], mdl_istall[CNT_W-1:0], mdl_flush[CNT_W-1:0]});
    end else begin
      mem_busy = (s.mem_dren || s.mem_dwen) && !s.dhit;
      hazard   = s.ex_dren && s.ex_wsel != 0 &&
                 (s.ex_wsel == s.id_rs || (s.id_uses_rt && s.ex_wsel == s.id_rt));
      // bit order: pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl
      if (mem_busy)        ctrl = 8'h00;
      else if (s.mem_halt) ctrl = {3'b000, 1'b1, 1'b1, 2'b00, 1'b1};
      else if (s.ex_jump)  ctrl = {5'b11111, 1'b1, 1'b1, 1'b0};
      else if (hazard)     ctrl = {2'b00, 3'b111, 1'b0, 1'b1, 1'b0};
      else if (!s.ihit)    ctrl = {1'b0, 4'b1111, 1'b1, 2'b00};
      else                 ctrl = {5'b11111, 3'b000};
      exp_q.push_back({ctrl, 1'b0, mdl_dstall[CNT_W-1:0], mdl_istall[CNT_W-1:0], mdl_flush[CNT_W-1:0]});
      if (mem_busy)        mdl_dstall = sat_inc(mdl_dstall);
      else if (s.mem_halt) mdl_halted = 1;
      else if (s.ex_jump)  mdl_flush  = sat_inc(mdl_flush);
      else if (hazard)     mdl_halted = mdl_halted;
      else if (!s.ihit)    mdl_istall = sat_inc(mdl_istall);
    end
  endtask

  // Monitor: pop and compare on the falling edge, away from the active edge.
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
                 halted, dstall_cnt, istall_cnt, flush_cnt};
        checks++;
        if (act_v[W-1 -: 8] !== exp_v[W-1 -: 8]) begin
          errors++;
          $display("FAIL ctrl t=%0t got=%b want=%b", $time, act_v[W-1 -: 8], exp_v[W-1 -: 8]);
        end
        checks++;
        if (act_v[3*CNT_W] !== exp_v[3*CNT_W]) begin
          errors++;
          $display("FAIL halted t=%0t got=%b want=%b", $time, act_v[3*CNT_W], exp_v[3*CNT_W]);
        end
        checks++;
        if (act_v[3*CNT_W-1:0] !== exp_v[3*CNT_W-1:0]) begin
          errors++;
          $display("FAIL counters t=%0t got d/i/f=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                   act_v[3*CNT_W-1 -: CNT_W], act_v[2*CNT_W-1 -: CNT_W], act_v[CNT_W-1:0],
                   exp_v[3*CNT_W-1 -: CNT_W], exp_v[2*CNT_W-1 -: CNT_W], exp_v[CNT_W-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    stim_t s;
    int    budget;
    rst = 1'b1; ihit = 1'b0; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
    ex_dren = 1'b0; ex_wsel = '0; ex_jump = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;

    s = idle(); s.rst = 1'b1; s.ihit = 1'b0;
    repeat (2) step(s);
    step(idle());

    // Load-use on Rs, then the hazard is gone
    s = idle(); s.ex_dren = 1'b1; s.ex_wsel = 5'd9; s.id_rs = 5'd9;
    step(s);
    step(idle());
    // Load-use on Rt only counts when Rt is read
    s = idle(); s.ex_dren = 1'b1; s.ex_wsel = 5'd7; s.id_rt = 5'd7; s.id_rs = 5'd3;
    step(s);
    s.id_uses_rt = 1'b1;
    step(s);
    // Load to $0 never stalls
    s = idle(); s.ex_dren = 1'b1; s.ex_wsel = 5'd0; s.id_rs = 5'd0;
    step(s);

    // Data wait for 3 cycles, release on dhit
    s = idle(); s.mem_dren = 1'b1;
    repeat (3) step(s);
    s.dhit = 1'b1;
    step(s);
    step(idle());
    // Store wait too
    s = idle(); s.mem_dwen = 1'b1;
    step(s);
    s.dhit = 1'b1;
    step(s);

    // Jump beats load-use and ~ihit
    s = idle(); s.ex_jump = 1'b1; s.ihit = 1'b0; s.ex_dren = 1'b1; s.ex_wsel = 5'd4; s.id_rs = 5'd4;
    step(s);
    s = idle(); s.ihit = 1'b0; s.ex_dren = 1'b1; s.ex_wsel = 5'd4; s.id_rs = 5'd4;
    step(s);

    // Halt behind a pending data access
    s = idle(); s.mem_dren = 1'b1; s.mem_halt = 1'b1;
    repeat (2) step(s);
    s.dhit = 1'b1;
    step(s);
    s = idle(); s.ex_jump = 1'b1; s.ihit = 1'b0;
    repeat (10) step(s);
    s = idle(); s.rst = 1'b1;
    step(s);
    step(idle());

    // Saturate istall_cnt, then clear with reset
    s = idle(); s.ihit = 1'b0;
    repeat (20) step(s);
    s = idle(); s.rst = 1'b1;
    step(s);
    step(idle());

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s.rst        = ($urandom_range(0, 49) == 0);
      s.ihit       = ($urandom_range(0, 3) != 0);
      s.dhit       = ($urandom_range(0, 2) != 0);
      s.mem_dren   = ($urandom_range(0, 3) == 0);
      s.mem_dwen   = ($urandom_range(0, 5) == 0);
      s.mem_halt   = ($urandom_range(0, 40) == 0);
      s.ex_dren    = ($urandom_range(0, 1) == 0);
      s.ex_wsel    = REG_W'($urandom_range(0, 3));
      s.ex_jump    = ($urandom_range(0, 5) == 0);
      s.id_rs      = REG_W'($urandom_range(0, 3));
      s.id_rt      = REG_W'($urandom_range(0, 3));
      s.id_uses_rt = ($urandom_range(0, 1) == 0);
      step(s);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 8) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
